// File: rtl/stream_demux_1ton_if.sv
// ---------------------------------------------------------------------------
// stream_demux_1ton_if
// Handshake bundle for the 1-to-N stream demultiplexer.
//
// Signals
//   s_valid  producer -> demux   input word valid
//   s_ready  demux -> producer   demux can accept a word this cycle
//   s_data   producer -> demux   input word
//   s_sel    producer -> demux   destination channel index
//   m_valid  demux -> sinks      per-channel valid (one-hot or zero)
//   m_ready  sinks -> demux      per-channel ready
//   m_data   demux -> sinks      registered word shared by all channels
//   err_drop demux -> producer   one-cycle pulse after an out-of-range select
//
// Modports
//   slave  : the demux itself
//   master : the environment (producer plus sinks)
// ---------------------------------------------------------------------------
interface stream_demux_1ton_if #(
    parameter int DATA_W  = 8,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2
);
    logic               s_valid;
    logic               s_ready;
    logic [DATA_W-1:0]  s_data;
    logic [SEL_W-1:0]   s_sel;
    logic [NUM_OUT-1:0] m_valid;
    logic [NUM_OUT-1:0] m_ready;
    logic [DATA_W-1:0]  m_data;
    logic               err_drop;

    modport slave (
        input  s_valid, s_data, s_sel, m_ready,
        output s_ready, m_valid, m_data, err_drop
    );

    modport master (
        output s_valid, s_data, s_sel, m_ready,
        input  s_ready, m_valid, m_data, err_drop
    );
endinterface

// File: rtl/stream_demux_1ton.sv
// ---------------------------------------------------------------------------
// stream_demux_1ton
// Registered 1-to-N stream demultiplexer. One word is accepted per
// valid/ready handshake and steered to the output channel named by the
// select captured with it. A single output register gives one cycle of
// latency and full throughput while the selected sink is ready.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   bus       stream_demux_1ton_if.slave (input stream, N output streams,
//             err_drop pulse)
//   cnt_flat  per-channel 16-bit delivery counters, channel i at bits
//             [i*16 +: 16]; present only when DEMUX_CNT_EN is defined
//
// Optional feature macro: DEMUX_CNT_EN (per-channel delivery counters).
//
// State | meaning
// ------+-----------------------------------------------------------
// EMPTY | output register holds no word; s_ready is 1
// HOLD  | output register holds a word for channel sel_q
// ---------------------------------------------------------------------------
module stream_demux_1ton #(
    parameter int DATA_W  = 8,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    stream_demux_1ton_if.slave bus
`ifdef DEMUX_CNT_EN
    ,
    output logic [NUM_OUT*16-1:0] cnt_flat
`endif
);

    generate
        if (NUM_OUT < 2 || NUM_OUT > 8 || (1 << SEL_W) < NUM_OUT) begin : g_param_check
            $error("stream_demux_1ton: illegal NUM_OUT/SEL_W combination");
        end
    endgenerate

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    // NUM_OUT widened by one bit so an all-ones select still compares correctly.
    localparam logic [SEL_W:0] NUM_OUT_L = (SEL_W + 1)'(NUM_OUT);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              err_q, err_d;

    logic full;
    logic sel_ready;
    logic out_fire;
    logic in_fire;
    logic sel_legal;
    logic load;

    assign full = (state_q == ST_HOLD);

    // Only the ready of the channel currently holding the word matters.
    always_comb begin
        sel_ready = 1'b0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready = bus.m_ready[i];
            end
        end
    end

    assign out_fire  = full && sel_ready;
    assign bus.s_ready = !full || sel_ready;
    assign in_fire   = bus.s_valid && bus.s_ready;
    assign sel_legal = ({1'b0, bus.s_sel} < NUM_OUT_L);
    assign load      = in_fire && sel_legal;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        err_d   = in_fire && !sel_legal;

        if (load) begin
            data_d = bus.s_data;
            sel_d  = bus.s_sel;
        end

        case (state_q)
            ST_EMPTY: begin
                if (load) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // A reload in the same cycle as out_fire keeps the register full.
                if (out_fire && !load) begin
                    state_d = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        bus.m_valid = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            bus.m_valid[i] = full && (sel_q == SEL_W'(i));
        end
    end

    assign bus.m_data   = data_q;
    assign bus.err_drop = err_q;

`ifdef DEMUX_CNT_EN
    logic [15:0] cnt_q [NUM_OUT];

    // Counts deliveries only; dropped words never reach the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (out_fire) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (sel_q == SEL_W'(i)) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        cnt_flat = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            cnt_flat[i*16 +: 16] = cnt_q[i];
        end
    end
`endif

endmodule
